mult_sched: RTL and testbench

MULT_SCHED -- requirements
Module: mult_sched

---
 rtl/mult_sched_pkg.sv | 21 ++
 rtl/mult_sched_mult.sv | 69 ++++++
 rtl/mult_sched.sv | 166 ++++++++++++++++
 tb/tb_mult_sched.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mult_sched_pkg.sv
// mult_sched_pkg
//   Shared types and constants for the multiplier scheduler slice.
//   - state_e : scheduler sequencing states
//   - OP_A_W  : operand A width
//   - OP_B_W  : operand B width
//   - PROD_W  : width of the scaled product (bits [17:8] of A*B)
`timescale 1ns/1ps
package mult_sched_pkg;

   localparam int unsigned OP_A_W = 10;
   localparam int unsigned OP_B_W = 8;
   localparam int unsigned PROD_W = 10;

   typedef enum logic [1:0] {
      IDLE,
      START,
      WAIT,
      DONE
   } state_e;

endpackage : mult_sched_pkg

// File: rtl/mult_sched_mult.sv
// mult
//   Sequential shift-add multiplier, OP_A_W x OP_B_W, returning product
//   bits [17:8]. One partial-product step per clock after start.
//   Ports:
//     clk_i    : clock, rising edge
//     rst_ni   : asynchronous active-low reset
//     start_i  : one-cycle pulse, samples a_i/b_i
//     a_i, b_i : unsigned operands
//     ready_o  : high for one cycle when prod_o is valid
//     prod_o   : (a*b) >> 8
`timescale 1ns/1ps
module mult
   import mult_sched_pkg::*;
(
   input  logic              clk_i,
   input  logic              rst_ni,
   input  logic              start_i,
   input  logic [OP_A_W-1:0] a_i,
   input  logic [OP_B_W-1:0] b_i,
   output logic              ready_o,
   output logic [PROD_W-1:0] prod_o
);

   localparam logic [3:0] STEPS = 4'(OP_B_W);

   logic [OP_A_W-1:0] a_q;
   logic [PROD_W-1:0] hi_q, hi_d;
   logic [OP_B_W-1:0] lo_q, lo_d;
   logic [3:0]        cnt_q;
   logic              run_q;
   logic [OP_A_W:0]   sum;

   // Right-shifting accumulator: {hi, lo} starts as {0, B}; each step adds A
   // into hi when lo[0] is set and shifts the pair right. After OP_B_W steps
   // hi holds product bits [17:8] and the low half has shifted out through lo.
   always_comb begin
      sum  = {1'b0, hi_q} + (lo_q[0] ? {1'b0, a_q} : '0);
      hi_d = sum[OP_A_W:1];
      lo_d = {sum[0], lo_q[OP_B_W-1:1]};
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         a_q   <= '0;
         hi_q  <= '0;
         lo_q  <= '0;
         cnt_q <= '0;
         run_q <= 1'b0;
      end else if (start_i) begin
         a_q   <= a_i;
         hi_q  <= '0;
         lo_q  <= b_i;
         cnt_q <= STEPS;
         run_q <= 1'b1;
      end else if (run_q) begin
         if (cnt_q != '0) begin
            hi_q  <= hi_d;
            lo_q  <= lo_d;
            cnt_q <= cnt_q - 4'd1;
         end else begin
            run_q <= 1'b0;
         end
      end
   end

   assign ready_o = run_q && (cnt_q == '0);
   assign prod_o  = hi_q;

endmodule : mult

// File: rtl/mult_sched.sv
// mult_sched
//   Round-robin scheduler sharing one shift-add multiplier among NUM_CH
//   requesting channels.
//   Optional feature: define MULT_SCHED_ZERO_SKIP_EN to bypass the
//   multiplier when the winning channel has a zero operand.
//   Ports:
//     clk_i   : clock, rising edge
//     rst_ni  : asynchronous active-low reset
//     req_i   : per-channel level request, held until ack_o
//     op_a_i  : packed per-channel operand A (NUM_CH x OP_A_W)
//     op_b_i  : packed per-channel operand B (NUM_CH x OP_B_W)
//     ack_o   : one-hot pulse, operands of that channel latched
//     done_o  : one-hot pulse, prod_o holds that channel's result
//     prod_o  : (A*B) >> 8, held until the next done_o
//     busy_o  : high whenever the scheduler is not idle
`timescale 1ns/1ps
module mult_sched
   import mult_sched_pkg::*;
#(
   parameter int unsigned NUM_CH = 3
)(
   input  logic                     clk_i,
   input  logic                     rst_ni,
   input  logic [NUM_CH-1:0]        req_i,
   input  logic [NUM_CH*OP_A_W-1:0] op_a_i,
   input  logic [NUM_CH*OP_B_W-1:0] op_b_i,
   output logic [NUM_CH-1:0]        ack_o,
   output logic [NUM_CH-1:0]        done_o,
   output logic [PROD_W-1:0]        prod_o,
   output logic                     busy_o
);

   localparam int unsigned IDX_W = (NUM_CH > 2) ? 2 : 1;

   state_e            state_q, state_d;
   logic [IDX_W-1:0]  idx_q, ptr_q, win_idx;
   logic              any_req;
   int unsigned       cand;
   logic [OP_A_W-1:0] a_q, win_a;
   logic [OP_B_W-1:0] b_q, win_b;
   logic [PROD_W-1:0] prod_q, mul_prod;
   logic              mul_start, mul_rdy;
   logic [NUM_CH-1:0] sel_onehot;
`ifdef MULT_SCHED_ZERO_SKIP_EN
   logic              skip_q, win_zero;
`endif

   // Round-robin search starting one past the last granted channel.
   always_comb begin
      any_req = 1'b0;
      win_idx = '0;
      cand    = 0;
      for (int unsigned k = 1; k <= NUM_CH; k++) begin
         cand = (32'(ptr_q) + k) % NUM_CH;
         if (!any_req && req_i[cand]) begin
            any_req = 1'b1;
            win_idx = IDX_W'(cand);
         end
      end
      win_a = op_a_i[32'(win_idx)*OP_A_W +: OP_A_W];
      win_b = op_b_i[32'(win_idx)*OP_B_W +: OP_B_W];
`ifdef MULT_SCHED_ZERO_SKIP_EN
      win_zero = (win_a == '0) || (win_b == '0);
`endif
   end

   // State register
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) state_q <= IDLE;
      else         state_q <= state_d;
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: begin
            if (any_req) begin
`ifdef MULT_SCHED_ZERO_SKIP_EN
               state_d = win_zero ? DONE : START;
`else
               state_d = START;
`endif
            end
         end
         START:   state_d = WAIT;
         WAIT:    if (mul_rdy) state_d = DONE;
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Output logic
   always_comb begin
      sel_onehot = NUM_CH'(1) << idx_q;
      ack_o      = '0;
      done_o     = '0;
      mul_start  = 1'b0;
      busy_o     = (state_q != IDLE);
      case (state_q)
         START: begin
            ack_o     = sel_onehot;
            mul_start = 1'b1;
         end
         DONE: begin
            done_o = sel_onehot;
`ifdef MULT_SCHED_ZERO_SKIP_EN
            // A skipped grant acknowledges and completes in the same cycle.
            if (skip_q) ack_o = sel_onehot;
`endif
         end
         default: ;
      endcase
   end

   // Operand/index latch, result capture and round-robin pointer
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         a_q    <= '0;
         b_q    <= '0;
         idx_q  <= '0;
         ptr_q  <= IDX_W'(NUM_CH - 1);
         prod_q <= '0;
`ifdef MULT_SCHED_ZERO_SKIP_EN
         skip_q <= 1'b0;
`endif
      end else begin
         case (state_q)
            IDLE: begin
               if (any_req) begin
                  a_q   <= win_a;
                  b_q   <= win_b;
                  idx_q <= win_idx;
`ifdef MULT_SCHED_ZERO_SKIP_EN
                  skip_q <= win_zero;
                  if (win_zero) prod_q <= '0;
`endif
               end
            end
            WAIT: begin
               if (mul_rdy) prod_q <= mul_prod;
            end
            DONE: begin
               ptr_q <= idx_q;
`ifdef MULT_SCHED_ZERO_SKIP_EN
               skip_q <= 1'b0;
`endif
            end
            default: ;
         endcase
      end
   end

   assign prod_o = prod_q;

   mult u_mult (
      .clk_i   (clk_i),
      .rst_ni  (rst_ni),
      .start_i (mul_start),
      .a_i     (a_q),
      .b_i     (b_q),
      .ready_o (mul_rdy),
      .prod_o  (mul_prod)
   );

endmodule : mult_sched

// File: tb/tb_mult_sched.sv
// tb_mult_sched
//   Self-checking bench for mult_sched (NUM_CH = 3). A transaction-level
//   model predicts grant order (round-robin over pending requests), the
//   fixed ack/done timing and the scaled product from plain arithmetic.
`timescale 1ns/1ps
module tb_mult_sched;
   import mult_sched_pkg::*;

   localparam int unsigned NUM_CH = 3;

   logic                     clk = 1'b0;
   logic                     rst_n;
   logic [NUM_CH-1:0]        req;
   logic [NUM_CH*OP_A_W-1:0] op_a;
   logic [NUM_CH*OP_B_W-1:0] op_b;
   logic [NUM_CH-1:0]        ack, done;
   logic [PROD_W-1:0]        prod;
   logic                     busy;

   mult_sched #(.NUM_CH(NUM_CH)) dut (
      .clk_i  (clk),
      .rst_ni (rst_n),
      .req_i  (req),
      .op_a_i (op_a),
      .op_b_i (op_b),
      .ack_o  (ack),
      .done_o (done),
      .prod_o (prod),
      .busy_o (busy)
   );

   always #5 clk = ~clk;

   int n_chk  = 0;
   int n_fail = 0;

   // model state
   logic [NUM_CH-1:0] pend;
   int unsigned       opa [NUM_CH];
   int unsigned       opb [NUM_CH];
   int                last_ch;
   int unsigned       last_prod;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
      end
   endtask

   task automatic drive();
      req = pend;
      for (int c = 0; c < NUM_CH; c++) begin
         op_a[c*OP_A_W +: OP_A_W] = OP_A_W'(opa[c]);
         op_b[c*OP_B_W +: OP_B_W] = OP_B_W'(opb[c]);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   function automatic int rr_pick(input logic [NUM_CH-1:0] p, input int last);
      for (int k = 1; k <= NUM_CH; k++) begin
         int c;
         c = (last + k) % NUM_CH;
         if (p[c]) return c;
      end
      return -1;
   endfunction

   task automatic raise(input int c);
      if (!pend[c]) begin
         pend[c] = 1'b1;
         opa[c]  = $urandom_range(0, 1023);
         opb[c]  = $urandom_range(0, 255);
         if ($urandom_range(0, 7) == 0) begin
            if ($urandom_range(0, 1) == 0) opa[c] = 0;
            else                           opb[c] = 0;
         end
      end
      drive();
   endtask

   task automatic check_quiet(input string tag);
      check_eq({tag, "_ack"},  ack,  0);
      check_eq({tag, "_done"}, done, 0);
      check_eq({tag, "_prod"}, prod, 0);
      check_eq({tag, "_busy"}, busy, 0);
   endtask

   // Called in the IDLE cycle (cycle 0) with channel ch pending on req.
   // Returns in the next IDLE cycle.
   task automatic run_txn(input int ch, input bit hold, input bit zap, input bit noise);
      int unsigned a, b, exp_p;
      bit          zero_path;
      a     = opa[ch];
      b     = opb[ch];
      exp_p = (a * b) >> 8;
`ifdef MULT_SCHED_ZERO_SKIP_EN
      zero_path = (a == 0) || (b == 0);
`else
      zero_path = 1'b0;
`endif
      step();                                   // cycle 1
      check_eq("ack_c1", ack, 1 << ch);
      check_eq("busy_c1", busy, 1);
      if (!hold) begin
         pend[ch] = 1'b0;
         drive();
      end
      if (zero_path) begin
         check_eq("done_skip", done, 1 << ch);
         check_eq("prod_skip", prod, 0);
         last_prod = 0;
         last_ch   = ch;
         step();                                // back in IDLE
         check_eq("busy_idle", busy, 0);
         check_eq("prod_hold", prod, last_prod);
         return;
      end
      check_eq("done_c1", done, 0);
      for (int cyc = 2; cyc <= 11; cyc++) begin
         step();
         if (cyc == 2 && !hold) begin
            opa[ch] = zap ? 0 : $urandom_range(0, 1023);
            opb[ch] = zap ? 0 : $urandom_range(0, 255);
            drive();
         end
         if (cyc < 11) begin
            check_eq("ack_wait", ack, 0);
            check_eq("done_wait", done, 0);
            check_eq("prod_wait", prod, last_prod);
         end else begin
            check_eq("done_c11", done, 1 << ch);
            check_eq("prod_c11", prod, exp_p);
            check_eq("ack_c11", ack, 0);
            check_eq("busy_c11", busy, 1);
         end
         if (noise && $urandom_range(0, 3) == 0)
            raise(int'($urandom_range(0, NUM_CH - 1)));
      end
      last_prod = exp_p;
      last_ch   = ch;
      step();                                   // cycle 12, IDLE
      check_eq("busy_idle", busy, 0);
      check_eq("prod_hold", prod, last_prod);
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      pend  = '0;
      drive();
      last_prod = 0;
      last_ch   = NUM_CH - 1;
      step();
      step();
      check_quiet("rst");
      rst_n = 1'b1;
      step();
   endtask

   initial begin
      int w;
      rst_n = 1'b0;
      pend  = '0;
      for (int c = 0; c < NUM_CH; c++) begin
         opa[c] = 0;
         opb[c] = 0;
      end
      drive();
      last_prod = 0;
      last_ch   = NUM_CH - 1;
      step();
      step();
      check_quiet("por");
      rst_n = 1'b1;
      step();
      check_quiet("idle0");

      // single request, full-scale operands
      opa[0] = 1023; opb[0] = 255; pend = 3'b001; drive();
      run_txn(0, 1'b0, 1'b0, 1'b0);
      check_eq("t1_prod", prod, 1019);

      // all-channel contention from reset, requests held
      do_reset();
      for (int c = 0; c < NUM_CH; c++) begin
         opa[c] = $urandom_range(1, 1023);
         opb[c] = $urandom_range(1, 255);
      end
      pend = '1;
      drive();
      for (int g = 0; g < 4; g++) begin
         w = rr_pick(pend, last_ch);
         run_txn(w, 1'b1, 1'b0, 1'b0);
      end
      pend = '0;
      drive();
      step();
      check_eq("contention_end_busy", busy, 0);

      // operands changed after ack
      opa[1] = 512; opb[1] = 128; pend = 3'b010; drive();
      run_txn(1, 1'b0, 1'b1, 1'b0);
      check_eq("t3_prod", prod, 256);

      // reset while waiting on the multiplier
      opa[1] = $urandom_range(1, 1023); opb[1] = $urandom_range(1, 255);
      pend = 3'b010; drive();
      step();                                   // cycle 1
      check_eq("t4_ack", ack, 3'b010);
      pend = '0; drive();
      repeat (4) step();                        // cycle 5
      check_eq("t4_busy_pre", busy, 1);
      rst_n = 1'b0;
      #1;
      check_quiet("t4_async");
      step();
      check_eq("t4_done_rst", done, 0);
      rst_n = 1'b1;
      last_prod = 0;
      last_ch   = NUM_CH - 1;
      for (int i = 0; i < 12; i++) begin
         step();
         check_eq("t4_no_done", done, 0);
      end
      opa[0] = 256; opb[0] = 2; pend = 3'b001; drive();
      run_txn(0, 1'b0, 1'b0, 1'b0);
      check_eq("t4_prod", prod, 2);

      // zero operand
      opa[2] = 0; opb[2] = 77; pend = 3'b100; drive();
      run_txn(2, 1'b0, 1'b0, 1'b0);
      check_eq("t5_prod", prod, 0);

      // randomized traffic
      for (int r = 0; r < 40; r++) begin
         if (pend == '0) begin
            for (int c = 0; c < NUM_CH; c++)
               if ($urandom_range(0, 1) == 1) raise(c);
            if (pend == '0) raise(int'($urandom_range(0, NUM_CH - 1)));
         end
         w = rr_pick(pend, last_ch);
         run_txn(w, 1'b0, 1'b0, 1'b1);
      end
      pend = '0;
      drive();
      step();

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule : tb_mult_sched
